// File: rtl/exp7_unidade_controle.sv
// ============================================================================
// exp7_unidade_controle
// ----------------------------------------------------------------------------
// Moore control unit for the memory game. It reads the status lines of the
// game datapath (exp6_fluxo_dados) and drives every one of that datapath's
// control inputs. Each round it plays a preview of the stored LED sequence,
// then collects and checks the player's moves. After every correct round it
// grows the sequence by one. The game ends in win, error or timeout.
//
// Optional feature macro: JOGO_TIMEOUT_EN
//   defined   -> the play timer counts while waiting for a move, and
//                controle_timeout ends the game in fim_timeout.
//   undefined -> the play timer never counts, controle_timeout is ignored,
//                and espera_jogada waits forever (timeout stays 0).
//
// Ports
//   clock                  : system clock, rising edge
//   reset                  : asynchronous, active-high; returns to inicial
//   iniciar                : start request (level)
//   jogo                   : ROM select, captured while in preparacao
//   igual                  : played key matches the stored value
//   enderecoIgualSequencia : address counter equals current sequence length
//   fimE                   : last round of the game reached
//   tem_jogada             : one-cycle pulse, a key was pressed
//   controle_timeout       : play timer expired
//   controle_timeout_led   : LED slot timer expired
//   zeraE/contaE           : clear/increment address counter
//   zeraS/contaS           : clear/increment sequence-length counter
//   zeraR/registraR        : clear/load move register
//   zeraT/contaT           : clear/run play timer
//   zeraT_leds/contaT_leds : clear/run LED slot timer
//   controla_leds          : LEDs show the ROM data
//   fase_preview           : datapath is in the preview phase
//   seletor_memoria        : registered ROM select
//   pronto/acertou/errou/timeout : game-end flags
//   db_estado              : current state code (debug)
// ============================================================================
module exp7_unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogo,
    input  logic       igual,
    input  logic       enderecoIgualSequencia,
    input  logic       fimE,
    input  logic       tem_jogada,
    input  logic       controle_timeout,
    input  logic       controle_timeout_led,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraS,
    output logic       contaS,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraT,
    output logic       contaT,
    output logic       zeraT_leds,
    output logic       contaT_leds,
    output logic       controla_leds,
    output logic       fase_preview,
    output logic       seletor_memoria,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    // Build-time switch for the play timeout. Keeping it as a constant lets
    // one copy of the FSM serve both builds. Without the feature, the timer
    // inputs fold away to constants.
`ifdef JOGO_TIMEOUT_EN
    localparam logic TIMEOUT_EN = 1'b1;
`else
    localparam logic TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        ST_INICIAL           = 4'd0,
        ST_PREPARACAO        = 4'd1,
        ST_MOSTRA_LED        = 4'd2,
        ST_APAGA_LED         = 4'd3,
        ST_PROXIMO_LED       = 4'd4,
        ST_PAUSA_LED         = 4'd5,
        ST_ZERA_LED          = 4'd6,
        ST_REINICIA_JOGADA   = 4'd7,
        ST_ESPERA_JOGADA     = 4'd8,
        ST_REGISTRA          = 4'd9,
        ST_COMPARACAO        = 4'd10,
        ST_PROXIMA_JOGADA    = 4'd11,
        ST_PROXIMA_SEQUENCIA = 4'd12,
        ST_FIM_ACERTOU       = 4'd13,
        ST_FIM_ERROU         = 4'd14,
        ST_FIM_TIMEOUT       = 4'd15
    } tEstado;

    // Bit positions inside the packed control word.
    localparam int B_ZERAE         = 15;
    localparam int B_CONTAE        = 14;
    localparam int B_ZERAS         = 13;
    localparam int B_CONTAS        = 12;
    localparam int B_ZERAR         = 11;
    localparam int B_REGISTRAR     = 10;
    localparam int B_ZERAT         = 9;
    localparam int B_CONTAT        = 8;
    localparam int B_ZERAT_LEDS    = 7;
    localparam int B_CONTAT_LEDS   = 6;
    localparam int B_CONTROLA_LEDS = 5;
    localparam int B_FASE_PREVIEW  = 4;
    localparam int B_PRONTO        = 3;
    localparam int B_ACERTOU       = 2;
    localparam int B_ERROU         = 1;
    localparam int B_TIMEOUT       = 0;

    tEstado      r_estado;
    tEstado      w_proximo;
    logic [15:0] r_controles;
    logic [15:0] w_controles;
    logic        r_seletor;
    logic        w_timeoutAtivo;

    assign w_timeoutAtivo = TIMEOUT_EN & controle_timeout;

    // Moore decode of one state into the full control word. Any control
    // that a state does not list stays 0.
    function automatic logic [15:0] decodeControles(input tEstado estado);
        logic [15:0] c;
        c = '0;
        case (estado)
            ST_PREPARACAO: begin
                c[B_ZERAE] = 1'b1;
                c[B_ZERAS] = 1'b1;
                c[B_ZERAR] = 1'b1;
                c[B_ZERAT] = 1'b1;
            end
            ST_MOSTRA_LED: begin
                c[B_FASE_PREVIEW]  = 1'b1;
                c[B_CONTROLA_LEDS] = 1'b1;
                c[B_CONTAT_LEDS]   = 1'b1;
            end
            ST_APAGA_LED: begin
                c[B_FASE_PREVIEW] = 1'b1;
                c[B_ZERAT_LEDS]   = 1'b1;
            end
            ST_PROXIMO_LED: begin
                c[B_FASE_PREVIEW] = 1'b1;
                c[B_CONTAE]       = 1'b1;
            end
            ST_PAUSA_LED: begin
                c[B_FASE_PREVIEW] = 1'b1;
                c[B_CONTAT_LEDS]  = 1'b1;
            end
            ST_ZERA_LED: begin
                c[B_FASE_PREVIEW] = 1'b1;
                c[B_ZERAT_LEDS]   = 1'b1;
            end
            ST_REINICIA_JOGADA: begin
                c[B_ZERAE] = 1'b1;
                c[B_ZERAT] = 1'b1;
                c[B_ZERAR] = 1'b1;
            end
            ST_ESPERA_JOGADA: begin
                c[B_CONTAT] = TIMEOUT_EN;
            end
            ST_REGISTRA: begin
                c[B_REGISTRAR] = 1'b1;
                c[B_ZERAT]     = 1'b1;
            end
            ST_PROXIMA_JOGADA: begin
                c[B_CONTAE] = 1'b1;
            end
            ST_PROXIMA_SEQUENCIA: begin
                c[B_CONTAS] = 1'b1;
                c[B_ZERAE]  = 1'b1;
            end
            ST_FIM_ACERTOU: begin
                c[B_PRONTO]  = 1'b1;
                c[B_ACERTOU] = 1'b1;
            end
            ST_FIM_ERROU: begin
                c[B_PRONTO] = 1'b1;
                c[B_ERROU]  = 1'b1;
            end
            ST_FIM_TIMEOUT: begin
                c[B_PRONTO]  = 1'b1;
                c[B_TIMEOUT] = TIMEOUT_EN;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state logic. Every entry into mostra_led goes through zera_led.
    // This gives the synchronous ROM one cycle to present the data for the
    // new address before the LEDs are enabled. For the same reason,
    // comparacao is always at least one cycle behind the last contaE/zeraE.
    always_comb begin
        w_proximo = r_estado;
        case (r_estado)
            ST_INICIAL:
                if (iniciar) w_proximo = ST_PREPARACAO;
            ST_PREPARACAO:
                w_proximo = ST_ZERA_LED;
            ST_MOSTRA_LED:
                if (controle_timeout_led) w_proximo = ST_APAGA_LED;
            ST_APAGA_LED:
                if (enderecoIgualSequencia) w_proximo = ST_REINICIA_JOGADA;
                else                        w_proximo = ST_PROXIMO_LED;
            ST_PROXIMO_LED:
                w_proximo = ST_PAUSA_LED;
            ST_PAUSA_LED:
                if (controle_timeout_led) w_proximo = ST_ZERA_LED;
            ST_ZERA_LED:
                w_proximo = ST_MOSTRA_LED;
            ST_REINICIA_JOGADA:
                w_proximo = ST_ESPERA_JOGADA;
            ST_ESPERA_JOGADA:
                if (tem_jogada)          w_proximo = ST_REGISTRA;
                else if (w_timeoutAtivo) w_proximo = ST_FIM_TIMEOUT;
            ST_REGISTRA:
                w_proximo = ST_COMPARACAO;
            ST_COMPARACAO:
                if (!igual)                       w_proximo = ST_FIM_ERROU;
                else if (!enderecoIgualSequencia) w_proximo = ST_PROXIMA_JOGADA;
                else if (fimE)                    w_proximo = ST_FIM_ACERTOU;
                else                              w_proximo = ST_PROXIMA_SEQUENCIA;
            ST_PROXIMA_JOGADA:
                w_proximo = ST_ESPERA_JOGADA;
            ST_PROXIMA_SEQUENCIA:
                w_proximo = ST_ZERA_LED;
            ST_FIM_ACERTOU, ST_FIM_ERROU, ST_FIM_TIMEOUT:
                if (iniciar) w_proximo = ST_PREPARACAO;
            default:
                w_proximo = ST_INICIAL;
        endcase
    end

    assign w_controles = decodeControles(w_proximo);

    // State register and registered outputs. The control word is loaded
    // from the decode of the next state. This keeps it aligned with
    // r_estado, so the outputs remain a pure function of the current state
    // and do not glitch. The ROM select is sampled from jogo while the FSM
    // sits in preparacao, and it holds for the rest of the game.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado    <= ST_INICIAL;
            r_controles <= '0;
            r_seletor   <= 1'b0;
        end else begin
            r_estado    <= w_proximo;
            r_controles <= w_controles;
            if (r_estado == ST_PREPARACAO) begin
                r_seletor <= jogo;
            end
        end
    end

    assign zeraE           = r_controles[B_ZERAE];
    assign contaE          = r_controles[B_CONTAE];
    assign zeraS           = r_controles[B_ZERAS];
    assign contaS          = r_controles[B_CONTAS];
    assign zeraR           = r_controles[B_ZERAR];
    assign registraR       = r_controles[B_REGISTRAR];
    assign zeraT           = r_controles[B_ZERAT];
    assign contaT          = r_controles[B_CONTAT];
    assign zeraT_leds      = r_controles[B_ZERAT_LEDS];
    assign contaT_leds     = r_controles[B_CONTAT_LEDS];
    assign controla_leds   = r_controles[B_CONTROLA_LEDS];
    assign fase_preview    = r_controles[B_FASE_PREVIEW];
    assign pronto          = r_controles[B_PRONTO];
    assign acertou         = r_controles[B_ACERTOU];
    assign errou           = r_controles[B_ERROU];
    assign timeout         = r_controles[B_TIMEOUT];
    assign seletor_memoria = r_seletor;
    assign db_estado       = r_estado;

endmodule

// File: tb/tb_exp7_unidade_controle.sv
// ============================================================================
// tb_exp7_unidade_controle
// ----------------------------------------------------------------------------
// Scoreboard bench for the memory-game control unit. The stimulus process
// drives one input vector per cycle and queues the state and control word
// expected after the next rising edge. The monitor process pops one entry
// each time the DUT presents a new state and compares it with the DUT.
// Expected states are written out by hand for each vector. Expected
// controls come from the state/output table.
// ============================================================================
module tb_exp7_unidade_controle;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       jogo = 1'b0;
    logic       igual = 1'b0;
    logic       enderecoIgualSequencia = 1'b0;
    logic       fimE = 1'b0;
    logic       tem_jogada = 1'b0;
    logic       controle_timeout = 1'b0;
    logic       controle_timeout_led = 1'b0;
    logic       zeraE, contaE, zeraS, contaS, zeraR, registraR, zeraT, contaT;
    logic       zeraT_leds, contaT_leds, controla_leds, fase_preview;
    logic       seletor_memoria, pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    // Input vector bits: {iniciar, jogo, igual, eis, fimE, tem, ct, ctl}
    localparam logic [7:0] I_INI   = 8'h80;
    localparam logic [7:0] I_JOGO  = 8'h40;
    localparam logic [7:0] I_IGUAL = 8'h20;
    localparam logic [7:0] I_EIS   = 8'h10;
    localparam logic [7:0] I_FIME  = 8'h08;
    localparam logic [7:0] I_TEM   = 8'h04;
    localparam logic [7:0] I_CT    = 8'h02;
    localparam logic [7:0] I_CTL   = 8'h01;
    localparam logic [7:0] I_NONE  = 8'h00;

`ifdef JOGO_TIMEOUT_EN
    localparam logic TMO_EN = 1'b1;
`else
    localparam logic TMO_EN = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic [16:0] outs;
    } tExp;

    tExp  scoreQ[$];
    int   testsRun = 0;
    int   testsFailed = 0;
    event asyncProbe;

    logic [16:0] actualOuts;

    exp7_unidade_controle dut (
        .clock                  (clock),
        .reset                  (reset),
        .iniciar                (iniciar),
        .jogo                   (jogo),
        .igual                  (igual),
        .enderecoIgualSequencia (enderecoIgualSequencia),
        .fimE                   (fimE),
        .tem_jogada             (tem_jogada),
        .controle_timeout       (controle_timeout),
        .controle_timeout_led   (controle_timeout_led),
        .zeraE                  (zeraE),
        .contaE                 (contaE),
        .zeraS                  (zeraS),
        .contaS                 (contaS),
        .zeraR                  (zeraR),
        .registraR              (registraR),
        .zeraT                  (zeraT),
        .contaT                 (contaT),
        .zeraT_leds             (zeraT_leds),
        .contaT_leds            (contaT_leds),
        .controla_leds          (controla_leds),
        .fase_preview           (fase_preview),
        .seletor_memoria        (seletor_memoria),
        .pronto                 (pronto),
        .acertou                (acertou),
        .errou                  (errou),
        .timeout                (timeout),
        .db_estado              (db_estado)
    );

    always #5 clock = ~clock;

    assign actualOuts = {zeraE, contaE, zeraS, contaS, zeraR, registraR,
                         zeraT, contaT, zeraT_leds, contaT_leds, controla_leds,
                         fase_preview, seletor_memoria, pronto, acertou,
                         errou, timeout};

    // Reference control word for a state, taken from the state/output table.
    // The bit order matches actualOuts.
    function automatic logic [16:0] expectedOuts(input logic [3:0] st, input logic sel);
        logic [16:0] o;
        o = '0;
        case (st)
            4'd1:  begin o[16] = 1'b1; o[14] = 1'b1; o[12] = 1'b1; o[10] = 1'b1; end
            4'd2:  begin o[5] = 1'b1; o[6] = 1'b1; o[7] = 1'b1; end
            4'd3:  begin o[5] = 1'b1; o[8] = 1'b1; end
            4'd4:  begin o[5] = 1'b1; o[15] = 1'b1; end
            4'd5:  begin o[5] = 1'b1; o[7] = 1'b1; end
            4'd6:  begin o[5] = 1'b1; o[8] = 1'b1; end
            4'd7:  begin o[16] = 1'b1; o[10] = 1'b1; o[12] = 1'b1; end
            4'd8:  begin o[9] = TMO_EN; end
            4'd9:  begin o[11] = 1'b1; o[10] = 1'b1; end
            4'd11: begin o[15] = 1'b1; end
            4'd12: begin o[13] = 1'b1; o[16] = 1'b1; end
            4'd13: begin o[3] = 1'b1; o[2] = 1'b1; end
            4'd14: begin o[3] = 1'b1; o[1] = 1'b1; end
            4'd15: begin o[3] = 1'b1; o[0] = 1'b1; end
            default: o = '0;
        endcase
        o[4] = sel;
        return o;
    endfunction

    // Drive one input vector at the falling edge and queue what the DUT
    // must show after the following rising edge.
    task automatic applyStimulus(input string name, input logic [7:0] inVec,
                                 input logic [3:0] expState, input logic expSel);
        tExp e;
        @(negedge clock);
        {iniciar, jogo, igual, enderecoIgualSequencia, fimE, tem_jogada,
         controle_timeout, controle_timeout_led} = inVec;
        e.name = name;
        e.st   = expState;
        e.outs = expectedOuts(expState, 1'b0) | {12'b0, expSel, 4'b0};
        scoreQ.push_back(e);
    endtask

    // Assert reset between clock edges. The idle response must appear
    // without waiting for the next rising edge.
    task automatic asyncReset(input string name);
        tExp e;
        @(negedge clock);
        #2;
        reset  = 1'b1;
        e.name = name;
        e.st   = 4'd0;
        e.outs = '0;
        scoreQ.push_back(e);
        -> asyncProbe;
    endtask

    task automatic checkOutput(input tExp e);
        testsRun++;
        if (db_estado !== e.st) begin
            testsFailed++;
            $display("[TB] FAIL %s state: got %0d expected %0d", e.name, db_estado, e.st);
        end
        testsRun++;
        if (actualOuts !== e.outs) begin
            testsFailed++;
            $display("[TB] FAIL %s outputs: got %b expected %b", e.name, actualOuts, e.outs);
        end
    endtask

    // Monitor: the DUT presents a new state after every rising edge, or at
    // once when an asynchronous reset is probed.
    initial begin
        tExp e;
        forever begin
            @(posedge clock or asyncProbe);
            #1;
            if (scoreQ.size() > 0) begin
                e = scoreQ.pop_front();
                checkOutput(e);
            end
        end
    end

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int drain;

        // Reset state
        applyStimulus("rst_hold", I_INI | I_JOGO, 4'd0, 1'b0);
        applyStimulus("rst_idle", I_NONE, 4'd0, 1'b0);
        reset = 1'b0;
        applyStimulus("idle", I_NONE, 4'd0, 1'b0);

        // Start with jogo=1: 0 -> 1 -> 6 -> 2
        applyStimulus("start", I_INI | I_JOGO, 4'd1, 1'b0);
        applyStimulus("prep", I_JOGO, 4'd6, 1'b1);
        applyStimulus("zera_led", I_NONE, 4'd2, 1'b1);

        // Round 1: single LED, then play
        applyStimulus("led_on", I_NONE, 4'd2, 1'b1);
        applyStimulus("led_tmo", I_CTL, 4'd3, 1'b1);
        applyStimulus("r1_last", I_EIS, 4'd7, 1'b1);
        applyStimulus("reinicia", I_NONE, 4'd8, 1'b1);
        applyStimulus("wait", I_NONE, 4'd8, 1'b1);
        applyStimulus("jogada", I_TEM, 4'd9, 1'b1);
        applyStimulus("registra", I_NONE, 4'd10, 1'b1);
        applyStimulus("seq_ok", I_IGUAL | I_EIS, 4'd12, 1'b1);
        applyStimulus("prox_seq", I_NONE, 4'd6, 1'b1);
        applyStimulus("r2_zera0", I_NONE, 4'd2, 1'b1);

        // Round 2: two LED slots with one dark pause between them
        applyStimulus("r2_led0", I_CTL, 4'd3, 1'b1);
        applyStimulus("r2_apaga0", I_NONE, 4'd4, 1'b1);
        applyStimulus("r2_prox", I_NONE, 4'd5, 1'b1);
        applyStimulus("r2_pausa", I_NONE, 4'd5, 1'b1);
        applyStimulus("r2_pausa_fim", I_CTL, 4'd6, 1'b1);
        applyStimulus("r2_zera1", I_NONE, 4'd2, 1'b1);
        applyStimulus("r2_led1", I_CTL, 4'd3, 1'b1);
        applyStimulus("r2_last", I_EIS, 4'd7, 1'b1);
        applyStimulus("r2_reinicia", I_NONE, 4'd8, 1'b1);

        // Round 2 play: correct move, then final move wins
        applyStimulus("r2_j0", I_TEM, 4'd9, 1'b1);
        applyStimulus("r2_reg0", I_NONE, 4'd10, 1'b1);
        applyStimulus("r2_ok0", I_IGUAL, 4'd11, 1'b1);
        applyStimulus("r2_next", I_NONE, 4'd8, 1'b1);
        applyStimulus("tem_wins", I_TEM | I_CT, 4'd9, 1'b1);
        applyStimulus("r2_reg1", I_NONE, 4'd10, 1'b1);
        applyStimulus("win", I_IGUAL | I_EIS | I_FIME, 4'd13, 1'b1);
        applyStimulus("win_hold", I_NONE, 4'd13, 1'b1);

        // Restart from fim_acertou with jogo=0
        applyStimulus("restart", I_INI, 4'd1, 1'b1);
        applyStimulus("prep2", I_NONE, 4'd6, 1'b0);
        applyStimulus("g2_zera", I_NONE, 4'd2, 1'b0);
        applyStimulus("g2_led", I_CTL, 4'd3, 1'b0);
        applyStimulus("g2_last", I_EIS, 4'd7, 1'b0);
        applyStimulus("g2_reinicia", I_NONE, 4'd8, 1'b0);

        // Play timeout, then a wrong move
`ifdef JOGO_TIMEOUT_EN
        applyStimulus("tmo", I_CT, 4'd15, 1'b0);
        applyStimulus("tmo_hold", I_NONE, 4'd15, 1'b0);
        applyStimulus("tmo_restart", I_INI, 4'd1, 1'b0);
        applyStimulus("g3_prep", I_NONE, 4'd6, 1'b0);
        applyStimulus("g3_zera", I_NONE, 4'd2, 1'b0);
        applyStimulus("g3_led", I_CTL, 4'd3, 1'b0);
        applyStimulus("g3_last", I_EIS, 4'd7, 1'b0);
        applyStimulus("g3_reinicia", I_NONE, 4'd8, 1'b0);
`else
        applyStimulus("tmo_ignored", I_CT, 4'd8, 1'b0);
`endif
        applyStimulus("e_jogada", I_TEM, 4'd9, 1'b0);
        applyStimulus("e_reg", I_NONE, 4'd10, 1'b0);
        applyStimulus("erro", I_NONE, 4'd14, 1'b0);
        applyStimulus("erro_hold", I_NONE, 4'd14, 1'b0);

        // Asynchronous reset in the middle of the preview
        applyStimulus("e_restart", I_INI | I_JOGO, 4'd1, 1'b0);
        applyStimulus("e_prep", I_JOGO, 4'd6, 1'b1);
        applyStimulus("e_zera", I_NONE, 4'd2, 1'b1);
        asyncReset("rst_mid_preview");
        applyStimulus("rst_mid_hold", I_NONE, 4'd0, 1'b0);
        reset = 1'b0;
        applyStimulus("after_rst", I_NONE, 4'd0, 1'b0);

        drain = 0;
        while (scoreQ.size() > 0 && drain < 10) begin
            @(posedge clock);
            drain++;
        end
        #2;
        if (scoreQ.size() > 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drain: got %0d pending entries expected 0", scoreQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
